ram_wb_dualport_fwd: RTL and testbench
======================================

Name: ram_wb_dualport_fwd

Overview:
Parametrised dual-port Wishbone RAM for Harvard CPUs (instruction port I, data port D), generalising the fixed 32-bit, 1-cycle Harvard RAM. It adds:
- configurable data width, depth and read latency;
- cross-port write-to-read forwarding and defined write-collision priority;
- out-of-range error termination.

It sits between the CPU bus ports and on-chip block RAM.

Parameters:
AWIDTH, 13, byte-address width.
DWIDTH, 32, data width; one of 16, 32 or 64.
DEPTH, 2048, implemented words; must be ≤ 2^(AWIDTH-log2(DWIDTH/8)).
RD_LAT, 1, cycles from accept to ack; 1 or 2 (2 adds an output register stage).
FORWARD, 1, enables cross-port forwarding when 1.

Ports:
wb_clk_i  in  1  clock; all logic is on its rising edge.
wb_rst_i  in  1  synchronous, active-high reset.
iwb_adr_i / dwb_adr_i  in  AWIDTH  byte address.
iwb_dat_i / dwb_dat_i  in  DWIDTH  write data.
iwb_dat_o / dwb_dat_o  out  DWIDTH  read data.
iwb_we_i / dwb_we_i  in  1  write enable.
iwb_stb_i / dwb_stb_i  in  1  strobe.
iwb_sel_i / dwb_sel_i  in  DWIDTH/8  byte enables.
iwb_ack_o / dwb_ack_o  out  1  normal termination.
iwb_err_o / dwb_err_o  out  1  out-of-range termination.
coll_o  out  1  one-cycle pulse on a same-word write collision.

Behaviour:
- Word index: adr[AWIDTH-1:log2(DWIDTH/8)]. Low address bits are ignored.
- Reset values: all ack, err and coll_o are 0; dat_o is 0; both port FSMs are IDLE. RAM contents are not cleared.
- Reset mid-access: pending ack/err is dropped and read data is discarded. No access is accepted while wb_rst_i=1.
- Per-port FSM states: IDLE, WAIT, TERM.
  - IDLE: stb=1 means the access is accepted this cycle (the accept cycle). Next state is TERM if RD_LAT=1, WAIT if RD_LAT=2.
  - WAIT → TERM.
  - TERM: exactly one of ack or err is high for one cycle; next state is IDLE.
- With stb held, accesses complete every RD_LAT+1 cycles. A write commits once, in the accept cycle, even if stb is held longer.
- Out-of-range: index ≥ DEPTH gives no RAM write, dat_o=0, and err instead of ack, at the same latency.
- Reads: dat_o holds the word as of the accept edge and is stable from the TERM cycle until the next accept.
- Same-port write: write-first. dat_o returns the merged word after the write.
- Forwarding (FORWARD=1): if the other port writes the same word in the same accept cycle, bytes it selects appear in dat_o with its new data. With FORWARD=0 those bytes return old data.
- Collision: both ports write the same in-range word in the same cycle.
  - Per byte, D wins where both sel bits are set; bytes selected by only one port take that port's data.
  - coll_o=1 in the cycle after the accept edge.
  - Each port's write-first readback reflects the final stored word.
- Accesses on the two ports are fully independent when word indices differ. No stall ever occurs.
- Byte enables: sel=0 on a write changes nothing, but the port still acks.

Decomposition:
- Package ram_wb_pkg holds:
  - a port state enum (IDLE/WAIT/TERM);
  - a clog2 function;
  - a byte-merge function (old word, new word, sel → merged word);
  - constant NBYTES = DWIDTH/8.
- Sub-module ram_wb_port_ctrl, instantiated twice, contains the per-port FSM, range check, ack/err generation and the optional RD_LAT=2 output stage.
- The top level holds the RAM array, the merge/priority logic and forwarding.

Test Plan:
1. Reset, then D writes 0xDEADBEEF to byte address 0x10 with sel=F. dwb_ack_o pulses at accept+1. An I-port read of 0x10 then returns 0xDEADBEEF with iwb_ack_o at accept+1.
2. RD_LAT=2, I stb held 6 cycles reading 0x0. Ack occurs on cycles 2 and 5 only; dat_o is stable between acks.
3. Same cycle: D writes 0x11223344 sel=0011 to word 4 while I reads word 4, which holds 0xAAAAAAAA. FORWARD=1: I gets 0xAAAA3344. FORWARD=0: I gets 0xAAAAAAAA.
4. Both ports write word 8: I writes 0x01020304 sel=1111, D writes 0xF0F0F0F0 sel=1100. Stored word is 0xF0F00304; coll_o pulses once; both readbacks are 0xF0F00304.
5. DEPTH=1024, D write to word 1024. dwb_err_o=1 and ack=0 at accept+RD_LAT. Word 0 is unchanged (no aliasing).
6. Assert wb_rst_i in a WAIT cycle (RD_LAT=2). No ack or err follows; outputs are 0 on the next cycle; a new access after reset completes normally.

Source files
------------

// File: rtl/ram_wb_pkg.sv
// ram_wb_pkg
//   Shared definitions for the dual-port Wishbone RAM:
//     - port_state_e : per-port access FSM states (IDLE / WAIT / TERM)
//     - clog2()      : elaboration-time ceiling log2
//     - nbytes()     : byte lanes for a given data width
//     - merge_bytes(): byte-enable merge of a new word over an old word
//   The merge works on the widest supported word (64 bits). Narrower
//   users zero-extend their operands and truncate the result.
package ram_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a strobe
    WAIT = 2'd1,  // extra latency cycle (RD_LAT = 2 only)
    TERM = 2'd2   // ack or err is driven for exactly this cycle
  } port_state_e;

  localparam int MAX_DWIDTH = 64;
  localparam int NBYTES_MAX = MAX_DWIDTH / 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int nbytes(input int dwidth);
    return dwidth / 8;
  endfunction

  // Bytes whose sel bit is set come from new_word, the rest from old_word.
  function automatic logic [MAX_DWIDTH-1:0] merge_bytes(
    input logic [MAX_DWIDTH-1:0] old_word,
    input logic [MAX_DWIDTH-1:0] new_word,
    input logic [NBYTES_MAX-1:0] sel
  );
    logic [MAX_DWIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < NBYTES_MAX; b++) begin
      if (sel[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_wb_port_ctrl.sv
// ram_wb_port_ctrl
//   One Wishbone slave port of the dual-port RAM: access FSM, address
//   range check, ack/err termination and the read-data output register
//   (plus an extra pipeline stage when RD_LAT = 2).
//
//   Ports:
//     clk, rst   rising-edge clock, synchronous active-high reset
//     stb        Wishbone strobe
//     adr        byte address (low byte-lane bits ignored)
//     rdata      write-first / forwarded read word for this port's accept
//                cycle, produced by the top level
//     accept     high in the cycle an access is accepted
//     idx        word index derived from adr
//     in_range   idx addresses an implemented word
//     ack, err   one-cycle termination in the TERM state
//     dat        read data returned to the bus
module ram_wb_port_ctrl
  import ram_wb_pkg::*;
#(
  parameter int AWIDTH = 13,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 2048,
  parameter int RD_LAT = 1,
  localparam int LSB    = clog2(nbytes(DWIDTH)),
  localparam int IWIDTH = AWIDTH - LSB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stb,
  input  logic [AWIDTH-1:0] adr,
  input  logic [DWIDTH-1:0] rdata,
  output logic              accept,
  output logic [IWIDTH-1:0] idx,
  output logic              in_range,
  output logic              ack,
  output logic              err,
  output logic [DWIDTH-1:0] dat
);

  port_state_e       state;
  port_state_e       state_nxt;
  logic              err_q;
  logic [DWIDTH-1:0] dat_q;
  logic [DWIDTH-1:0] capture;

  // Byte-lane bits select a byte within the word and play no part here.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^adr[LSB-1:0];

  assign idx      = adr[AWIDTH-1:LSB];
  assign in_range = (int'(idx) < DEPTH);

  // Accept only from IDLE, and never while reset is asserted.
  assign accept = (state == IDLE) && stb && !rst;

  // Out-of-range accesses return zero data.
  assign capture = in_range ? rdata : '0;

  // ---------------------------------------------------------------------
  // FSM: state register
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent
  // simulation and mismatch synthesis.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next-state logic
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (RD_LAT == 2) ? WAIT : TERM;
      WAIT:    state_nxt = TERM;
      TERM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Reset squashes a termination still in flight.
  always_comb begin
    ack = (state == TERM) && !err_q && !rst;
    err = (state == TERM) &&  err_q && !rst;
  end

  // Range result is frozen at accept so the termination type matches the
  // accepted address even if adr changes afterwards.
  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= !in_range;
  end

  // Read data path. dat only changes on the edge that leads into TERM, so
  // it is stable from TERM until the next access delivers new data.
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DWIDTH-1:0] stage_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          stage_q <= '0;
          dat_q   <= '0;
        end else begin
          if (accept)         stage_q <= capture;
          if (state == WAIT)  dat_q   <= stage_q;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst)         dat_q <= '0;
        else if (accept) dat_q <= capture;
      end
    end
  endgenerate

  assign dat = dat_q;

endmodule

// File: rtl/ram_wb_dualport_fwd.sv
// ram_wb_dualport_fwd
//   Dual-port Wishbone RAM for a Harvard CPU: instruction port (iwb_*) and
//   data port (dwb_*) share one word array. Each port accepts an access in
//   any IDLE cycle with stb high and terminates RD_LAT cycles later with
//   ack (in range) or err (word index >= DEPTH). Writes are byte-enabled
//   and write-first. When both ports write the same word in the same cycle
//   the data port wins overlapping bytes and coll_o pulses the next cycle.
//   With FORWARD = 1 a read also sees the other port's same-cycle write.
//
//   Ports:
//     wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//     iwb_*/dwb_* adr_i      byte address
//     iwb_*/dwb_* dat_i      write data
//     iwb_*/dwb_* dat_o      read data
//     iwb_*/dwb_* we_i       write enable
//     iwb_*/dwb_* stb_i      strobe
//     iwb_*/dwb_* sel_i      byte enables
//     iwb_*/dwb_* ack_o      normal termination
//     iwb_*/dwb_* err_o      out-of-range termination
//     coll_o                 same-word write collision pulse
module ram_wb_dualport_fwd
  import ram_wb_pkg::*;
#(
  parameter int AWIDTH  = 13,
  parameter int DWIDTH  = 32,
  parameter int DEPTH   = 2048,
  parameter int RD_LAT  = 1,
  parameter int FORWARD = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  // instruction port
  input  logic [AWIDTH-1:0]     iwb_adr_i,
  input  logic [DWIDTH-1:0]     iwb_dat_i,
  output logic [DWIDTH-1:0]     iwb_dat_o,
  input  logic                  iwb_we_i,
  input  logic                  iwb_stb_i,
  input  logic [DWIDTH/8-1:0]   iwb_sel_i,
  output logic                  iwb_ack_o,
  output logic                  iwb_err_o,
  // data port
  input  logic [AWIDTH-1:0]     dwb_adr_i,
  input  logic [DWIDTH-1:0]     dwb_dat_i,
  output logic [DWIDTH-1:0]     dwb_dat_o,
  input  logic                  dwb_we_i,
  input  logic                  dwb_stb_i,
  input  logic [DWIDTH/8-1:0]   dwb_sel_i,
  output logic                  dwb_ack_o,
  output logic                  dwb_err_o,
  // status
  output logic                  coll_o
);

  localparam int NBYTES = nbytes(DWIDTH);
  localparam int IWIDTH = AWIDTH - clog2(NBYTES);
  localparam int MWIDTH = (DEPTH > 1) ? clog2(DEPTH) : 1;

  // Byte merge at this instance's width, built on the package helper.
  function automatic logic [DWIDTH-1:0] merge_w(
    input logic [DWIDTH-1:0] old_word,
    input logic [DWIDTH-1:0] new_word,
    input logic [NBYTES-1:0] sel
  );
    return DWIDTH'(merge_bytes(MAX_DWIDTH'(old_word), MAX_DWIDTH'(new_word),
                               NBYTES_MAX'(sel)));
  endfunction

  // NOTE: the array has no reset; clearing it would defeat block-RAM
  // inference, and software must not rely on its power-up contents.
  logic [DWIDTH-1:0] mem [DEPTH];

  logic              i_accept, d_accept;
  logic [IWIDTH-1:0] i_idx, d_idx;
  logic              i_in_range, d_in_range;
  logic [DWIDTH-1:0] i_rdata, d_rdata;
  logic [DWIDTH-1:0] i_old, d_old;
  logic [MWIDTH-1:0] i_maddr, d_maddr;
  logic              i_wr, d_wr, same_word, coll, coll_q;

  ram_wb_port_ctrl #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) u_iport (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .stb      (iwb_stb_i),
    .adr      (iwb_adr_i),
    .rdata    (i_rdata),
    .accept   (i_accept),
    .idx      (i_idx),
    .in_range (i_in_range),
    .ack      (iwb_ack_o),
    .err      (iwb_err_o),
    .dat      (iwb_dat_o)
  );

  ram_wb_port_ctrl #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) u_dport (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .stb      (dwb_stb_i),
    .adr      (dwb_adr_i),
    .rdata    (d_rdata),
    .accept   (d_accept),
    .idx      (d_idx),
    .in_range (d_in_range),
    .ack      (dwb_ack_o),
    .err      (dwb_err_o),
    .dat      (dwb_dat_o)
  );

  // A write commits only in its accept cycle and only when in range, so an
  // out-of-range index can never alias onto a low word.
  assign i_wr      = i_accept && iwb_we_i && i_in_range;
  assign d_wr      = d_accept && dwb_we_i && d_in_range;
  assign same_word = (i_idx == d_idx);
  assign coll      = i_wr && d_wr && same_word;

  // In-range indices always fit the array, so the upper bits are zero.
  assign i_maddr = i_idx[MWIDTH-1:0];
  assign d_maddr = d_idx[MWIDTH-1:0];
  assign i_old   = i_in_range ? mem[i_maddr] : '0;
  assign d_old   = d_in_range ? mem[d_maddr] : '0;

  // Write-first readback per port. The I-port write is applied before the
  // D-port write so the data port wins overlapping bytes. The other port's
  // write is folded in when forwarding is enabled, and always on a
  // collision, so both ports see the word that is actually stored.
  always_comb begin
    i_rdata = i_old;
    if (i_wr) i_rdata = merge_w(i_rdata, iwb_dat_i, iwb_sel_i);
    if (d_wr && same_word && i_accept && (FORWARD != 0 || i_wr))
      i_rdata = merge_w(i_rdata, dwb_dat_i, dwb_sel_i);

    d_rdata = d_old;
    if (i_wr && same_word && d_accept && (FORWARD != 0 || d_wr))
      d_rdata = merge_w(d_rdata, iwb_dat_i, iwb_sel_i);
    if (d_wr) d_rdata = merge_w(d_rdata, dwb_dat_i, dwb_sel_i);
  end

  // Each writing port stores its fully merged word. On a collision both
  // merged words are identical, so the two writes agree.
  always_ff @(posedge wb_clk_i) begin
    if (i_wr) mem[i_maddr] <= i_rdata;
    if (d_wr) mem[d_maddr] <= d_rdata;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) coll_q <= 1'b0;
    else          coll_q <= coll;
  end

  assign coll_o = coll_q;

endmodule

// File: tb/tb_ram_wb_dualport_fwd.sv
// tb_ram_wb_dualport_fwd
//   Self-checking bench for ram_wb_dualport_fwd. Two instances are driven:
//     dut_a : DEPTH=1024, RD_LAT=1, FORWARD=1
//     dut_b : DEPTH=2048, RD_LAT=2, FORWARD=0
//   Expected values come from a word-array reference model updated with
//   plain byte arithmetic per transaction.
module tb_ram_wb_dualport_fwd;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int NB = 4;

  typedef struct {
    logic          en;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [NB-1:0] sel;
  } req_t;

  typedef struct {
    logic          iack;
    logic          ierr;
    logic [DW-1:0] idat;
    logic          dack;
    logic          derr;
    logic [DW-1:0] ddat;
    logic          coll;
  } obs_t;

  function automatic int depth_of(int k); return (k == 0) ? 1024 : 2048; endfunction
  function automatic int lat_of(int k);   return (k == 0) ? 1 : 2;       endfunction
  function automatic int fwd_of(int k);   return (k == 0) ? 1 : 0;       endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [2];
  logic [AW-1:0] iadr  [2];
  logic [DW-1:0] iwdat [2];
  logic [DW-1:0] irdat [2];
  logic          iwe   [2];
  logic          istb  [2];
  logic [NB-1:0] isel  [2];
  logic          iack  [2];
  logic          ierr  [2];
  logic [AW-1:0] dadr  [2];
  logic [DW-1:0] dwdat [2];
  logic [DW-1:0] drdat [2];
  logic          dwe   [2];
  logic          dstb  [2];
  logic [NB-1:0] dsel  [2];
  logic          dack  [2];
  logic          derr  [2];
  logic          coll  [2];

  ram_wb_dualport_fwd #(
    .AWIDTH(AW), .DWIDTH(DW), .DEPTH(1024), .RD_LAT(1), .FORWARD(1)
  ) dut_a (
    .wb_clk_i (clk),      .wb_rst_i (rst[0]),
    .iwb_adr_i(iadr[0]),  .iwb_dat_i(iwdat[0]), .iwb_dat_o(irdat[0]),
    .iwb_we_i (iwe[0]),   .iwb_stb_i(istb[0]),  .iwb_sel_i(isel[0]),
    .iwb_ack_o(iack[0]),  .iwb_err_o(ierr[0]),
    .dwb_adr_i(dadr[0]),  .dwb_dat_i(dwdat[0]), .dwb_dat_o(drdat[0]),
    .dwb_we_i (dwe[0]),   .dwb_stb_i(dstb[0]),  .dwb_sel_i(dsel[0]),
    .dwb_ack_o(dack[0]),  .dwb_err_o(derr[0]),
    .coll_o   (coll[0])
  );

  ram_wb_dualport_fwd #(
    .AWIDTH(AW), .DWIDTH(DW), .DEPTH(2048), .RD_LAT(2), .FORWARD(0)
  ) dut_b (
    .wb_clk_i (clk),      .wb_rst_i (rst[1]),
    .iwb_adr_i(iadr[1]),  .iwb_dat_i(iwdat[1]), .iwb_dat_o(irdat[1]),
    .iwb_we_i (iwe[1]),   .iwb_stb_i(istb[1]),  .iwb_sel_i(isel[1]),
    .iwb_ack_o(iack[1]),  .iwb_err_o(ierr[1]),
    .dwb_adr_i(dadr[1]),  .dwb_dat_i(dwdat[1]), .dwb_dat_o(drdat[1]),
    .dwb_we_i (dwe[1]),   .dwb_stb_i(dstb[1]),  .dwb_sel_i(dsel[1]),
    .dwb_ack_o(dack[1]),  .dwb_err_o(derr[1]),
    .coll_o   (coll[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference memory contents, one array per instance.
  logic [DW-1:0] model [2][2048];

  task automatic check(input string tag, input logic [DW-1:0] observed,
                       input logic [DW-1:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] put(input logic [DW-1:0] w,
                                        input logic [DW-1:0] d,
                                        input logic [NB-1:0] s);
    logic [DW-1:0] r;
    r = w;
    for (int b = 0; b < NB; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic req_t mk(input logic en, input logic we, input int adr,
                              input logic [DW-1:0] dat, input logic [NB-1:0] sel);
    req_t r;
    r.en = en; r.we = we; r.adr = AW'(adr); r.dat = dat; r.sel = sel;
    return r;
  endfunction

  function automatic req_t idle();
    return mk(1'b0, 1'b0, 0, '0, '0);
  endfunction

  function automatic req_t rand_req(input int k);
    int word;
    if (k == 0 && $urandom_range(0, 9) == 0) word = 1024 + int'($urandom_range(0, 3));
    else                                      word = int'($urandom_range(0, 8));
    return mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              word * 4 + int'($urandom_range(0, 3)), $urandom,
              NB'($urandom_range(0, 15)));
  endfunction

  task automatic drive(input int k, input req_t ri, input req_t rd);
    istb[k] = ri.en; iwe[k] = ri.we; iadr[k] = ri.adr; iwdat[k] = ri.dat; isel[k] = ri.sel;
    dstb[k] = rd.en; dwe[k] = rd.we; dadr[k] = rd.adr; dwdat[k] = rd.dat; dsel[k] = rd.sel;
  endtask

  function automatic obs_t sample(input int k);
    obs_t o;
    o.iack = iack[k]; o.ierr = ierr[k]; o.idat = irdat[k];
    o.dack = dack[k]; o.derr = derr[k]; o.ddat = drdat[k];
    o.coll = coll[k];
    return o;
  endfunction

  // One access on either or both ports of instance k, accepted in the
  // current cycle. Checks every cycle up to one past the termination and
  // returns what both ports showed at the termination cycle.
  task automatic xact(input int k, input req_t ri, input req_t rd, output obs_t res);
    int            wi, wd, lat;
    logic          in_i, in_d, i_wr, d_wr, coll_exp;
    logic [DW-1:0] old_i, old_d, exp_i, exp_d;
    obs_t          o;
    string         p;
    p   = (k == 0) ? "a" : "b";
    lat = lat_of(k);
    wi  = int'(ri.adr) / NB;
    wd  = int'(rd.adr) / NB;
    in_i = wi < depth_of(k);
    in_d = wd < depth_of(k);
    i_wr = ri.en && ri.we && in_i;
    d_wr = rd.en && rd.we && in_d;
    coll_exp = i_wr && d_wr && (wi == wd);
    old_i = in_i ? model[k][wi] : '0;
    old_d = in_d ? model[k][wd] : '0;
    // D applied last: it owns bytes both ports select.
    if (i_wr) model[k][wi] = put(model[k][wi], ri.dat, ri.sel);
    if (d_wr) model[k][wd] = put(model[k][wd], rd.dat, rd.sel);
    if (!in_i)                         exp_i = '0;
    else if (fwd_of(k) != 0 || coll_exp) exp_i = model[k][wi];
    else                               exp_i = i_wr ? put(old_i, ri.dat, ri.sel) : old_i;
    if (!in_d)                         exp_d = '0;
    else if (fwd_of(k) != 0 || coll_exp) exp_d = model[k][wd];
    else                               exp_d = d_wr ? put(old_d, rd.dat, rd.sel) : old_d;

    drive(k, ri, rd);
    res = sample(k);
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(k, idle(), idle());
      o = sample(k);
      check($sformatf("%s_coll_c%0d", p, c), DW'(o.coll), DW'(c == 1 && coll_exp));
      check($sformatf("%s_i_ack_c%0d", p, c), DW'(o.iack), DW'(ri.en && c == lat && in_i));
      check($sformatf("%s_i_err_c%0d", p, c), DW'(o.ierr), DW'(ri.en && c == lat && !in_i));
      check($sformatf("%s_d_ack_c%0d", p, c), DW'(o.dack), DW'(rd.en && c == lat && in_d));
      check($sformatf("%s_d_err_c%0d", p, c), DW'(o.derr), DW'(rd.en && c == lat && !in_d));
      if (c == lat) begin
        if (ri.en) check($sformatf("%s_i_dat", p), o.idat, exp_i);
        if (rd.en) check($sformatf("%s_d_dat", p), o.ddat, exp_d);
        res = o;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t          o;
    logic [DW-1:0] exp0;

    // Reset both instances.
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      drive(k, idle(), idle());
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      o = sample(k);
      check("rst_iack", DW'(o.iack), '0);
      check("rst_ierr", DW'(o.ierr), '0);
      check("rst_idat", o.idat, '0);
      check("rst_dack", DW'(o.dack), '0);
      check("rst_derr", DW'(o.derr), '0);
      check("rst_ddat", o.ddat, '0);
      check("rst_coll", DW'(o.coll), '0);
      rst[k] = 1'b0;
    end

    // D write then I read of byte address 0x10, 1-cycle latency.
    xact(0, idle(), mk(1, 1, 'h10, 32'hDEADBEEF, 4'hF), o);
    xact(0, mk(1, 0, 'h10, '0, '0), idle(), o);
    check("t1_read", o.idat, 32'hDEADBEEF);

    // Give every word the random traffic will touch a known value.
    for (int k = 0; k < 2; k++)
      for (int w = 0; w <= 8; w++)
        xact(k, idle(), mk(1, 1, w * 4, $urandom, 4'hF), o);

    // Same-cycle D partial write and I read of word 4.
    for (int k = 0; k < 2; k++) begin
      xact(k, idle(), mk(1, 1, 'h10, 32'hAAAAAAAA, 4'hF), o);
      xact(k, mk(1, 0, 'h10, '0, '0), mk(1, 1, 'h10, 32'h11223344, 4'b0011), o);
      check((k == 0) ? "t3_fwd" : "t3_nofwd", o.idat,
            (k == 0) ? 32'hAAAA3344 : 32'hAAAAAAAA);
    end

    // Write collision on word 8.
    for (int k = 0; k < 2; k++) begin
      xact(k, mk(1, 1, 'h20, 32'h01020304, 4'hF), mk(1, 1, 'h20, 32'hF0F0F0F0, 4'b1100), o);
      check("t4_i_readback", o.idat, 32'hF0F00304);
      check("t4_d_readback", o.ddat, 32'hF0F00304);
      xact(k, mk(1, 0, 'h21, '0, '0), idle(), o);
      check("t4_stored", o.idat, 32'hF0F00304);
    end

    // Out-of-range write (word 1024 with DEPTH=1024) must not alias word 0.
    xact(0, idle(), mk(1, 1, 'h0, 32'h55AA55AA, 4'hF), o);
    xact(0, idle(), mk(1, 1, 'h1000, 32'h12345678, 4'hF), o);
    check("t5_err", DW'(o.derr), DW'(1));
    check("t5_no_ack", DW'(o.dack), '0);
    xact(0, mk(1, 0, 'h0, '0, '0), idle(), o);
    check("t5_word0", o.idat, 32'h55AA55AA);

    // RD_LAT=2 with stb held for six cycles reading word 0.
    exp0 = model[1][0];
    drive(1, mk(1, 0, 'h2, '0, '0), idle());
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 6) drive(1, idle(), idle());
      o = sample(1);
      check($sformatf("t2_ack_c%0d", c), DW'(o.iack), DW'(c == 2 || c == 5));
      if (c >= 2 && c <= 5) check($sformatf("t2_dat_c%0d", c), o.idat, exp0);
    end

    // Reset in the WAIT cycle drops the pending termination.
    drive(1, mk(1, 0, 'h10, '0, '0), idle());
    @(posedge clk); #1;
    drive(1, idle(), idle());
    o = sample(1);
    check("t6_wait_ack", DW'(o.iack), '0);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    o = sample(1);
    rst[1] = 1'b0;
    check("t6_rst_ack", DW'(o.iack), '0);
    check("t6_rst_err", DW'(o.ierr), '0);
    check("t6_rst_dat", o.idat, '0);
    @(posedge clk); #1;
    o = sample(1);
    check("t6_post_ack", DW'(o.iack), '0);
    check("t6_post_err", DW'(o.ierr), '0);
    xact(1, mk(1, 0, 'h10, '0, '0), idle(), o);
    check("t6_recover_ack", DW'(o.iack), DW'(1));

    // Randomised traffic on both instances.
    for (int n = 0; n < 160; n++) begin
      req_t ri, rd;
      ri = rand_req(n % 2);
      rd = rand_req(n % 2);
      if (!ri.en && !rd.en) rd.en = 1'b1;
      xact(n % 2, ri, rd, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
